// File: rtl/tristate_bus_owner_ctrl.sv
// Bus-ownership sequencer for N_DRV tristate buffers sharing one net: round-robin
// grant, bounded hold while others wait, and TURN_CYC all-off cycles between owners.
module tristate_bus_owner_ctrl #(
    parameter int N_DRV    = 4,
    parameter int TURN_CYC = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_DRV-1:0]         req,
    output logic [N_DRV-1:0]         en,
    output logic [$clog2(N_DRV)-1:0] owner,
    output logic                     owner_vld,
    output logic                     bus_turn,
    output logic [1:0]               dbg_state
);

    localparam int IW = $clog2(N_DRV);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    // req is a level request; en is the grant and stays high until the owner
    // drops req or is pre-empted by the hold limit. There is no other handshake.
    state_t           state_q, state_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [3:0]       turn_q, turn_d;
    logic [N_DRV-1:0] en_q, en_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic             vld_q;
    logic             bt_q, bt_d;

    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    scan_idx;
    logic             own_req;
    logic             others_req;
    logic             hold_limit;
    logic [IW-1:0]    next_ptr;

    // First requester at or after rr_q, wrapping at N_DRV (not at 2**IW).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < N_DRV; i++) begin
            if (int'(rr_q) + i >= N_DRV) begin
                scan_idx = IW'(int'(rr_q) + i - N_DRV);
            end else begin
                scan_idx = IW'(int'(rr_q) + i);
            end
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // en_q is one-hot in DRIVE, so masking with it isolates the owner's request.
    assign own_req    = |(req & en_q);
    assign others_req = |(req & ~en_q);
    assign hold_limit = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD));
    assign next_ptr   = (owner_q == IW'(N_DRV - 1)) ? '0 : owner_q + IW'(1);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        en_d    = en_q;
        owner_d = owner_q;
        bt_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                en_d = '0;
                if (win_found) begin
                    state_d = S_DRIVE;
                    en_d    = N_DRV'(1) << win_idx;
                    owner_d = win_idx;
                    hold_d  = HW'(1);
                end
            end
            S_DRIVE: begin
                if (!own_req || (hold_limit && others_req)) begin
                    state_d = S_TURN;
                    en_d    = '0;
                    bt_d    = 1'b1;
                    turn_d  = 4'(TURN_CYC);
                    rr_d    = next_ptr;
                end else if ((MAX_HOLD != 0) && !hold_limit) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_TURN: begin
                en_d = '0;
                if (turn_q <= 4'd1) begin
                    turn_d = '0;
                    if (win_found) begin
                        state_d = S_DRIVE;
                        en_d    = N_DRV'(1) << win_idx;
                        owner_d = win_idx;
                        hold_d  = HW'(1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    turn_d = turn_q - 4'd1;
                    bt_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
            en_q    <= '0;
            owner_q <= '0;
            vld_q   <= 1'b0;
            bt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            en_q    <= en_d;
            owner_q <= owner_d;
            vld_q   <= |en_d;
            bt_q    <= bt_d;
        end
    end

    assign en        = en_q;
    assign owner     = owner_q;
    assign owner_vld = vld_q;
    assign bus_turn  = bt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tristate_bus_owner_ctrl.sv
// Bench for tristate_bus_owner_ctrl: four parameter sets driven together, each checked
// every cycle against a behavioural ownership model, plus directed scenarios on set 0.
module tb_tristate_bus_owner_ctrl;

    localparam int NI = 4;
    localparam int CN[NI] = '{4, 5, 3, 2};
    localparam int CT[NI] = '{2, 3, 1, 3};
    localparam int CM[NI] = '{4, 0, 4, 4};

    typedef struct {
        bit drv;
        int own;
        int gap;
        int hold;
        int rr;
    } mdl_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] req_v [NI];
    bit          rand_all;

    wire [3:0] en0;  wire [1:0] ow0;  wire vld0, bt0;  wire [1:0] st0;
    wire [4:0] en1;  wire [2:0] ow1;  wire vld1, bt1;  wire [1:0] st1;
    wire [2:0] en2;  wire [1:0] ow2;  wire vld2, bt2;  wire [1:0] st2;
    wire [1:0] en3;  wire [0:0] ow3;  wire vld3, bt3;  wire [1:0] st3;

    logic [15:0] en_v  [NI];
    int          ow_v  [NI];
    logic        vld_v [NI];
    logic        bt_v  [NI];

    mdl_t        mdl      [NI];
    logic [15:0] prev_en  [NI];
    int          zero_run [NI];
    bit          had_own  [NI];
    int          wait_c   [NI][16];
    logic [15:0] exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    tristate_bus_owner_ctrl #(.N_DRV(4), .TURN_CYC(2), .MAX_HOLD(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req_v[0][3:0]), .en(en0), .owner(ow0),
        .owner_vld(vld0), .bus_turn(bt0), .dbg_state(st0));
    tristate_bus_owner_ctrl #(.N_DRV(5), .TURN_CYC(3), .MAX_HOLD(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req_v[1][4:0]), .en(en1), .owner(ow1),
        .owner_vld(vld1), .bus_turn(bt1), .dbg_state(st1));
    tristate_bus_owner_ctrl #(.N_DRV(3), .TURN_CYC(1), .MAX_HOLD(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req_v[2][2:0]), .en(en2), .owner(ow2),
        .owner_vld(vld2), .bus_turn(bt2), .dbg_state(st2));
    tristate_bus_owner_ctrl #(.N_DRV(2), .TURN_CYC(3), .MAX_HOLD(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req_v[3][1:0]), .en(en3), .owner(ow3),
        .owner_vld(vld3), .bus_turn(bt3), .dbg_state(st3));

    always_comb begin
        en_v[0] = 16'(en0);  ow_v[0] = int'(ow0);  vld_v[0] = vld0;  bt_v[0] = bt0;
        en_v[1] = 16'(en1);  ow_v[1] = int'(ow1);  vld_v[1] = vld1;  bt_v[1] = bt1;
        en_v[2] = 16'(en2);  ow_v[2] = int'(ow2);  vld_v[2] = vld2;  bt_v[2] = bt2;
        en_v[3] = 16'(en3);  ow_v[3] = int'(ow3);  vld_v[3] = vld3;  bt_v[3] = bt3;
    end

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, how many idle turnaround cycles remain,
    // and where the round-robin scan starts.
    function automatic int arb(input int n, input int rr, input logic [15:0] r);
        int k;
        for (int i = 0; i < n; i++) begin
            k = (rr + i) % n;
            if (r[4'(k)]) return k;
        end
        return -1;
    endfunction

    function automatic mdl_t mstep(input mdl_t s, input int n, input int t, input int m,
                                   input logic [15:0] r);
        mdl_t        ns;
        logic [15:0] others;
        int          k;
        ns = s;
        if (s.drv) begin
            others = r & ~(16'(1) << s.own);
            if (!r[4'(s.own)] || (m != 0 && s.hold == m && others != 0)) begin
                ns.drv = 1'b0;
                ns.rr  = (s.own + 1) % n;
                ns.gap = t;
            end else if (m != 0 && s.hold < m) begin
                ns.hold = s.hold + 1;
            end
        end else if (s.gap > 1) begin
            ns.gap = s.gap - 1;
        end else begin
            ns.gap = 0;
            k = arb(n, s.rr, r);
            if (k >= 0) begin
                ns.drv  = 1'b1;
                ns.own  = k;
                ns.hold = 1;
            end
        end
        return ns;
    endfunction

    task automatic reset_model();
        for (int g = 0; g < NI; g++) begin
            mdl[g]      = '{drv: 1'b0, own: 0, gap: 0, hold: 0, rr: 0};
            prev_en[g]  = '0;
            zero_run[g] = 0;
            had_own[g]  = 1'b0;
            for (int i = 0; i < 16; i++) wait_c[g][i] = 0;
        end
    endtask

    task automatic compare(input int g);
        logic [15:0] e_en;
        logic [15:0] rise;
        int          bnd;
        e_en = mdl[g].drv ? (16'(1) << mdl[g].own) : 16'(0);
        check($sformatf("en_i%0d", g), 32'(en_v[g]), 32'(e_en));
        check($sformatf("owner_i%0d", g), 32'(ow_v[g]), 32'(mdl[g].own));
        check($sformatf("vld_i%0d", g), 32'(vld_v[g]), 32'(mdl[g].drv));
        check($sformatf("turn_i%0d", g), 32'(bt_v[g]), 32'(!mdl[g].drv && mdl[g].gap > 0));
        check($sformatf("onehot0_i%0d", g), 32'($onehot0(en_v[g])), 32'(1));
        rise = en_v[g] & ~prev_en[g];
        if (rise != 0 && had_own[g])
            check($sformatf("gap_i%0d", g),
                  32'((zero_run[g] >= CT[g]) ? CT[g] : zero_run[g]), 32'(CT[g]));
        bnd = (CN[g] - 1) * (CM[g] + CT[g]) + CT[g] + 1;
        for (int i = 0; i < CN[g]; i++) begin
            if (CM[g] != 0 && rise[4'(i)])
                check($sformatf("latency_i%0d_d%0d", g, i),
                      32'((wait_c[g][i] > bnd) ? wait_c[g][i] : bnd), 32'(bnd));
            wait_c[g][i] = (req_v[g][4'(i)] && !en_v[g][4'(i)]) ? wait_c[g][i] + 1 : 0;
        end
        zero_run[g] = (en_v[g] == 0) ? zero_run[g] + 1 : 0;
        if (en_v[g] != 0) had_own[g] = 1'b1;
        prev_en[g] = en_v[g];
    endtask

    // driver: randomise background requests, step one edge, then compare
    task automatic cycle();
        for (int g = (rand_all ? 0 : 1); g < NI; g++)
            for (int i = 0; i < CN[g]; i++)
                if ($urandom_range(0, 5) == 0) req_v[g][4'(i)] = ~req_v[g][4'(i)];
        @(posedge clk);
        for (int g = 0; g < NI; g++)
            if (rst_n) mdl[g] = mstep(mdl[g], CN[g], CT[g], CM[g], req_v[g]);
        #1;
        for (int g = 0; g < NI; g++) compare(g);
    endtask

    task automatic wait_en0(input logic [15:0] pat, input int maxc, input string tag);
        int c;
        c = 0;
        while (en_v[0] != pat && c < maxc) begin
            cycle();
            c++;
        end
        check(tag, 32'(en_v[0]), 32'(pat));
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        reset_model();
        #1;
        check("async_en", 32'(en_v[0]), 32'(0));
        check("async_vld", 32'(vld_v[0]), 32'(0));
        check("async_owner", 32'(ow_v[0]), 32'(0));
        check("async_turn", 32'(bt_v[0]), 32'(0));
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int c;
        logic [15:0] e;
        rst_n    = 1'b0;
        rand_all = 1'b0;
        for (int g = 0; g < NI; g++) req_v[g] = '0;
        reset_model();

        // 1: reset with requests pending, first grant one edge after release
        req_v[0] = 16'b0101;
        repeat (3) cycle();
        check("t1_rst_en", 32'(en_v[0]), 32'(0));
        rst_n = 1'b1;
        cycle();
        check("t1_en", 32'(en_v[0]), 32'h1);
        check("t1_owner", 32'(ow_v[0]), 32'(0));

        // 2: owner 0 drops, driver 2 gets the bus after exactly two idle cycles
        req_v[0] = 16'b0100;
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("t2_gap_en", 32'(en_v[0]), 32'(0));
            check("t2_gap_turn", 32'(bt_v[0]), 32'(1));
        end
        cycle();
        check("t2_en", 32'(en_v[0]), 32'h4);
        check("t2_owner", 32'(ow_v[0]), 32'(2));

        // 3: all requesting, 4-cycle holds with 2-cycle gaps, order 3,0,1,2,...
        req_v[0] = 16'hF;
        c = 0;
        while (en_v[0] != 0 && c < 8) begin
            cycle();
            c++;
        end
        check("t3_release", 32'(en_v[0]), 32'(0));
        for (int k = 0; k < 48; k++)
            exp_q.push_back(((k % 6) < 2) ? 16'(0) : (16'(1) << ((3 + k / 6) % 4)));
        for (int k = 0; k < 48; k++) begin
            if (k > 0) cycle();
            e = exp_q.pop_front();
            check($sformatf("t3_seq%0d", k), 32'(en_v[0]), 32'(e));
        end

        // 4: lone requester is never forced off
        req_v[0] = 16'h2;
        wait_en0(16'h2, 12, "t4_grant");
        for (int k = 0; k < 50; k++) begin
            cycle();
            check("t4_hold", 32'(en_v[0]), 32'h2);
        end

        // 5: asynchronous reset mid-ownership, regrant without turnaround
        req_v[0] = 16'h8;
        wait_en0(16'h8, 12, "t5_grant");
        reset_pulse();
        cycle();
        check("t5_regrant", 32'(en_v[0]), 32'h8);
        check("t5_no_turn", 32'(bt_v[0]), 32'(0));

        // 6: random requests on every parameter set
        rand_all = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            if (k == 5000) reset_pulse();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
